// File: rtl/irq_ctrl_if.sv
// CPU memory-bus slot used by the interrupt controller: decoder/CPU side drives
// select, write strobe, register index and write data; the controller returns read data.
interface irq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cs;
  logic             wen;
  logic [2:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (output cs, output wen, output addr, output din, input dout);
  modport slave  (input cs, input wen, input addr, input din, output dout);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: collects request lines, presents the lowest
// eligible index to the CPU and sequences ack / in-service / end-of-interrupt.
module irq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NIRQ  = 32,
  parameter int unsigned VEC_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  irq_ctrl_if.slave        bus,
  input  logic [NIRQ-1:0]  irq_in,
  output logic             cpu_irq,
  output logic [VEC_W-1:0] cpu_vec,
  input  logic             cpu_ack
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_q, state_d;
  logic [NIRQ-1:0]  pend_q, pend_d;
  logic [NIRQ-1:0]  en_q, en_d;
  logic [NIRQ-1:0]  mode_q, mode_d;
  logic [NIRQ-1:0]  prev_q;
  logic             act_valid_q, act_valid_d;
  logic [VEC_W-1:0] act_vec_q, act_vec_d;
  logic             cpu_irq_q, cpu_irq_d;
  logic [VEC_W-1:0] cpu_vec_q, cpu_vec_d;

  logic             wr;
  logic             ack_take;
  logic             eoi;
  logic [NIRQ-1:0]  pend_view;
  logic [NIRQ-1:0]  eligible;
  logic [NIRQ-1:0]  ack_mask;
  logic [NIRQ-1:0]  set_v;
  logic [NIRQ-1:0]  clr_v;
  logic [VEC_W-1:0] winner;
  logic             found;
  logic [WIDTH-1:0] rdata;

  assign wr       = bus.cs & bus.wen;
  assign ack_take = (state_q == REQ) & cpu_ack;
  assign eoi      = wr & (bus.addr == 3'd4) & (state_q == SERVICE);

  // pend_q holds latched edges for edge bits and only the soft bit for level bits
  assign pend_view = pend_q | (irq_in & ~mode_q);
  assign eligible  = pend_view & en_q;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (eligible[i] && !found) begin
        winner = VEC_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ack_mask = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (ack_take && (VEC_W'(i) == cpu_vec_q)) ack_mask[i] = 1'b1;
    end
  end

  // Sets are OR'd in after clears so a same-cycle set always survives
  always_comb begin
    set_v  = irq_in & ~prev_q & mode_q;
    clr_v  = ack_mask;
    if (wr && (bus.addr == 3'd5)) set_v = set_v | bus.din[NIRQ-1:0];
    if (wr && (bus.addr == 3'd0)) clr_v = clr_v | bus.din[NIRQ-1:0];
    pend_d = (pend_q & ~clr_v) | set_v;
    en_d   = (wr && (bus.addr == 3'd1)) ? bus.din[NIRQ-1:0] : en_q;
    mode_d = (wr && (bus.addr == 3'd2)) ? bus.din[NIRQ-1:0] : mode_q;
  end

  always_comb begin
    state_d     = state_q;
    cpu_irq_d   = cpu_irq_q;
    cpu_vec_d   = cpu_vec_q;
    act_valid_d = act_valid_q;
    act_vec_d   = act_vec_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = REQ;
          cpu_irq_d = 1'b1;
          cpu_vec_d = winner;
        end
      end
      REQ: begin
        if (cpu_ack) begin
          state_d     = SERVICE;
          cpu_irq_d   = 1'b0;
          act_valid_d = 1'b1;
          act_vec_d   = cpu_vec_q;
        end else if (!found) begin
          state_d   = IDLE;
          cpu_irq_d = 1'b0;
        end else begin
          cpu_vec_d = winner;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_d     = IDLE;
          act_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      en_q        <= '0;
      mode_q      <= '0;
      prev_q      <= '0;
      act_valid_q <= 1'b0;
      act_vec_q   <= '0;
      cpu_irq_q   <= 1'b0;
      cpu_vec_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      prev_q      <= irq_in;
      act_valid_q <= act_valid_d;
      act_vec_q   <= act_vec_d;
      cpu_irq_q   <= cpu_irq_d;
      cpu_vec_q   <= cpu_vec_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.cs) begin
      case (bus.addr)
        3'd0: rdata[NIRQ-1:0] = pend_view;
        3'd1: rdata[NIRQ-1:0] = en_q;
        3'd2: rdata[NIRQ-1:0] = mode_q;
        3'd3: begin
          rdata[31]        = act_valid_q;
          rdata[VEC_W-1:0] = act_vec_q;
        end
        3'd6: rdata[1:0] = {state_q == SERVICE, cpu_irq_q};
        default: rdata = '0;
      endcase
    end
  end

  assign bus.dout = rdata;
  assign cpu_irq  = cpu_irq_q;
  assign cpu_vec  = cpu_vec_q;

endmodule
